// File: rtl/u_multiplier.sv
// Three-stage pipelined 32x32 unsigned multiplier with a full 64-bit product.
// The operands are registered, then four 16x16 partial products, then their sum.
module u_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [63:0] out
);

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] pp_ll;
    logic [31:0] pp_lh;
    logic [31:0] pp_hl;
    logic [31:0] pp_hh;
    logic [32:0] mid_sum;
    logic [63:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= in1;
            b_q <= in2;
        end
    end

    // Zero-extend each half so every product is evaluated at the full 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_ll <= '0;
            pp_lh <= '0;
            pp_hl <= '0;
            pp_hh <= '0;
        end else begin
            pp_ll <= {16'b0, a_q[15:0]}  * {16'b0, b_q[15:0]};
            pp_lh <= {16'b0, a_q[15:0]}  * {16'b0, b_q[31:16]};
            pp_hl <= {16'b0, a_q[31:16]} * {16'b0, b_q[15:0]};
            pp_hh <= {16'b0, a_q[31:16]} * {16'b0, b_q[31:16]};
        end
    end

    // The cross terms can carry into bit 32, so they are summed at 33 bits.
    always_comb begin
        mid_sum = {1'b0, pp_lh} + {1'b0, pp_hl};
        sum     = {pp_hh, 32'b0} + {15'b0, mid_sum, 16'b0} + {32'b0, pp_ll};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= sum;
        end
    end

endmodule

// File: tb/tb_u_multiplier.sv
// Self-checking bench for u_multiplier: a product delay-line model checked every
// cycle, plus hand-computed corner, carry, pipelining and reset cases.
module tb_u_multiplier;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [63:0] out;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEnable = 0;

    logic [63:0] hist [3] = '{64'd0, 64'd0, 64'd0};

    u_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the product sampled on an edge shows up two edges later; reset wipes all in flight.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0] <= 64'd0;
            hist[1] <= 64'd0;
            hist[2] <= 64'd0;
        end else begin
            hist[0] <= 64'(in1) * 64'(in2);
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    always @(negedge clk) begin
        if (checkEnable) begin
            testsRun++;
            if (out !== hist[2]) begin
                testsFailed++;
                $display("[TB] FAIL model_compare @%0t: got %h expected %h", $time, out, hist[2]);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1;
        in1 = a;
        in2 = b;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic checkOutput(input string name, input logic [63:0] exp);
        testsRun++;
        if (out !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, out, exp);
        end
        testsRun++;
        if (hist[2] !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s_model: got %h expected %h", name, hist[2], exp);
        end
    endtask

    task automatic holdCorner(input string name, input logic [31:0] a,
                              input logic [31:0] b, input logic [63:0] exp);
        applyStimulus(a, b);
        repeat (3) @(posedge clk);
        #1;
        checkOutput(name, exp);
        @(posedge clk);
        #1;
        checkOutput({name, "_hold"}, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        checkEnable = 1'b1;

        holdCorner("max_x_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        holdCorner("max_x_one",   32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF);
        holdCorner("zero_x_any",  32'h00000000, 32'hDEADBEEF, 64'h0);
        holdCorner("lo_half_sq",  32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001);
        holdCorner("hi_lo_carry", 32'h00010000, 32'h00010000, 64'h0000000100000000);
        holdCorner("msb_x_two",   32'h80000000, 32'h00000002, 64'h0000000100000000);

        applyStimulus(32'd2, 32'd3);
        applyStimulus(32'hFFFFFFFF, 32'd2);
        applyStimulus(32'h00010000, 32'h0000FFFF);
        @(posedge clk); #1; checkOutput("b2b_0", 64'd6);
        @(posedge clk); #1; checkOutput("b2b_1", 64'h1FFFFFFFE);
        @(posedge clk); #1; checkOutput("b2b_2", 64'hFFFF0000);

        // Async reset mid-cycle with a nonzero product on out.
        applyStimulus(32'd3, 32'd5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1; checkOutput("post_reset_e1", 64'd0);
        @(posedge clk); #1; checkOutput("post_reset_e2", 64'd0);
        @(posedge clk); #1; checkOutput("post_reset_e3", 64'd15);

        // Reset while two pairs are in flight; neither may surface.
        applyStimulus(32'd5, 32'd7);
        applyStimulus(32'd9, 32'd11);
        @(posedge clk); #2;
        rst_n = 1'b0;
        in1 = '0;
        in2 = '0;
        #1;
        checkOutput("flight_reset", 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("flight_discard", 64'd0);
        end

        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom, $urandom);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        checkEnable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
